prefetch_queue: RTL and testbench

// - Instruction word queue between the RX deserialiser and the decoder/scheduler.
// - Assembles serial RX data (NSHIFT bits/cycle, LSB first) into WORD_BITS words. Queues them FIFO.
// - Presents the head word to the decoder, and serves imm16 loads for the scheduler.
// - Tracks outstanding fetches. Generates prefetch requests; flushes on a PC write.

---
 rtl/prefetch_queue.sv | 138 +++++++++++++
 tb/tb_prefetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction word queue between the RX deserialiser and the decoder/scheduler.
//   Serial RX beats (NSHIFT bits, LSB first) are assembled into WORD_BITS words
//   and queued FIFO. The head word feeds the decoder and can be copied into an
//   imm register that is shifted out NSHIFT bits at a time. Outstanding fetches
//   are tracked to gate new fetch requests and to drop replies after a flush.
//
//   Build option: define IMM_ROTATE_EN to make next_imm_data rotate imm_reg
//   (immediate reusable after WORD_BITS/NSHIFT shifts); otherwise zeros fill.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   rx_data_valid     RX beat present on rx_pins
//   rx_pins           RX beat data (NSHIFT bits)
//   block_prefetch    suppress new fetch requests
//   fetch_request     ask TX to issue a read
//   fetch_started     TX accepted a read (pulse)
//   prefetch_idle     no fetch outstanding
//   flush             drop queue and in-flight fetches
//   inst_word         head word
//   inst_avail        queue non-empty
//   inst_take         decoder pops head
//   load_imm16        scheduler requests head as immediate (level)
//   imm16_loaded      head copied into imm register this cycle
//   next_imm_data     shift imm register by NSHIFT
//   imm_data_in       low NSHIFT bits of imm register
module prefetch_queue #(
  parameter int unsigned NSHIFT    = 2,
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data_valid,
  input  logic [NSHIFT-1:0]    rx_pins,
  input  logic                 block_prefetch,
  output logic                 fetch_request,
  input  logic                 fetch_started,
  output logic                 prefetch_idle,
  input  logic                 flush,
  output logic [WORD_BITS-1:0] inst_word,
  output logic                 inst_avail,
  input  logic                 inst_take,
  input  logic                 load_imm16,
  output logic                 imm16_loaded,
  input  logic                 next_imm_data,
  output logic [NSHIFT-1:0]    imm_data_in
);

  localparam int unsigned BEATS  = WORD_BITS / NSHIFT;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count, outstanding, discard, out_nxt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [WORD_BITS-1:0] asm_reg, asm_nxt, imm_reg;
  logic                 word_done, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign asm_nxt   = {rx_pins, asm_reg[WORD_BITS-1:NSHIFT]};
  assign word_done = rx_data_valid && (beat_cnt == BEAT_W'(BEATS - 1));

  assign inst_avail    = (count != '0);
  assign inst_word     = mem[rd_ptr];
  assign imm16_loaded  = load_imm16 && inst_avail && !flush;
  assign pop           = !flush && inst_avail && (imm16_loaded || inst_take);
  // A push into a full queue is only accepted when the head leaves this cycle.
  assign push          = word_done && (discard == '0) && !flush &&
                         ((count != CNT_W'(DEPTH)) || pop);
  assign fetch_request = !reset && !flush && !block_prefetch &&
                         (({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH));
  assign prefetch_idle = (outstanding == '0);
  assign imm_data_in   = imm_reg[NSHIFT-1:0];

  always_comb begin
    out_nxt = outstanding;
    if (fetch_started && !word_done && outstanding != CNT_W'(DEPTH))
      out_nxt = outstanding + 1'b1;
    else if (word_done && !fetch_started && outstanding != '0)
      out_nxt = outstanding - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt    <= '0;
      asm_reg     <= '0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      imm_reg     <= '0;
    end else begin
      if (rx_data_valid) begin
        asm_reg  <= asm_nxt;
        beat_cnt <= word_done ? '0 : beat_cnt + 1'b1;
      end

      outstanding <= out_nxt;
      // Everything still in flight after this cycle belongs to the old PC.
      if (flush)
        discard <= out_nxt;
      else if (word_done && discard != '0)
        discard <= discard - 1'b1;

      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end

      if (imm16_loaded)
        imm_reg <= inst_word;
      else if (next_imm_data)
`ifdef IMM_ROTATE_EN
        imm_reg <= {imm_reg[NSHIFT-1:0], imm_reg[WORD_BITS-1:NSHIFT]};
`else
        imm_reg <= {{NSHIFT{1'b0}}, imm_reg[WORD_BITS-1:NSHIFT]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= asm_nxt;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_data_valid = 1'b0;
  logic [1:0]  rx_pins = '0;
  logic        block_prefetch = 1'b0;
  logic        fetch_request;
  logic        fetch_started = 1'b0;
  logic        prefetch_idle;
  logic        flush = 1'b0;
  logic [15:0] inst_word;
  logic        inst_avail;
  logic        inst_take = 1'b0;
  logic        load_imm16 = 1'b0;
  logic        imm16_loaded;
  logic        next_imm_data = 1'b0;
  logic [1:0]  imm_data_in;

  int tests = 0;
  int fails = 0;

  prefetch_queue #(.NSHIFT(2), .WORD_BITS(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid), .rx_pins(rx_pins),
    .block_prefetch(block_prefetch), .fetch_request(fetch_request),
    .fetch_started(fetch_started), .prefetch_idle(prefetch_idle), .flush(flush),
    .inst_word(inst_word), .inst_avail(inst_avail), .inst_take(inst_take),
    .load_imm16(load_imm16), .imm16_loaded(imm16_loaded),
    .next_imm_data(next_imm_data), .imm_data_in(imm_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    fetch_started = 1'b1;
    tick();
    fetch_started = 1'b0;
  endtask

  // beats first..last of word w, LSB pair first
  task automatic beats(input logic [15:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rx_data_valid = 1'b1;
      rx_pins = 2'((w >> (2 * i)) & 16'h3);
      tick();
    end
    rx_data_valid = 1'b0;
  endtask

  task automatic take();
    inst_take = 1'b1;
    tick();
    inst_take = 1'b0;
  endtask

  initial begin
    logic [15:0] imm_w;
    logic [1:0]  exp_pair;

    // 1. reset state and basic queueing
    tick(); tick();
    check("rst_req", fetch_request, 0);
    check("rst_idle", prefetch_idle, 1);
    check("rst_avail", inst_avail, 0);
    check("rst_imm", imm_data_in, 0);
    reset = 1'b0;
    #1;
    check("t1_req0", fetch_request, 1);
    fetch();
    check("t1_req1", fetch_request, 1);
    fetch();
    check("t1_req2", fetch_request, 0);
    beats(16'h1234, 0, 6);
    check("t1_nobypass", inst_avail, 0);
    beats(16'h1234, 7, 7);
    check("t1_avail", inst_avail, 1);
    check("t1_word0", inst_word, 16'h1234);
    check("t1_req3", fetch_request, 0);
    beats(16'hABCD, 0, 7);
    check("t1_idle", prefetch_idle, 1);
    check("t1_head", inst_word, 16'h1234);
    take();
    check("t1_word1", inst_word, 16'hABCD);
    check("t1_req4", fetch_request, 1);
    take();
    check("t1_empty", inst_avail, 0);

    // 2. imm16 load and shift-out
    fetch();
    beats(16'hBEEF, 0, 7);
    load_imm16 = 1'b1;
    #1;
    check("t2_loaded", imm16_loaded, 1);
    tick();
    check("t2_loaded_once", imm16_loaded, 0);
    check("t2_popped", inst_avail, 0);
    load_imm16 = 1'b0;
    imm_w = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
`ifdef IMM_ROTATE_EN
      exp_pair = 2'((imm_w >> (2 * (i % 8))) & 16'h3);
`else
      exp_pair = (i < 8) ? 2'((imm_w >> (2 * i)) & 16'h3) : 2'b00;
`endif
      check($sformatf("t2_imm%0d", i), imm_data_in, exp_pair);
      next_imm_data = 1'b1;
      tick();
      next_imm_data = 1'b0;
    end

    // 3. flush with two fetches in flight
    fetch();
    fetch();
    beats(16'hFFFF, 0, 2);
    flush = 1'b1;
    #1;
    check("t3_req_flush", fetch_request, 0);
    tick();
    flush = 1'b0;
    beats(16'hFFFF, 3, 7);
    check("t3_drop1", inst_avail, 0);
    check("t3_busy1", prefetch_idle, 0);
    beats(16'hAAAA, 0, 6);
    check("t3_busy15", prefetch_idle, 0);
    beats(16'hAAAA, 7, 7);
    check("t3_idle16", prefetch_idle, 1);
    check("t3_drop2", inst_avail, 0);
    fetch();
    beats(16'h5555, 0, 7);
    check("t3_avail", inst_avail, 1);
    check("t3_word", inst_word, 16'h5555);
    take();

    // 4. full queue, pop and push in the same cycle
    fetch();
    fetch();
    beats(16'h1111, 0, 7);
    beats(16'h2222, 0, 7);
    check("t4_full_req", fetch_request, 0);
    fetch();
    check("t4_req_a", fetch_request, 0);
    beats(16'h3333, 0, 6);
    check("t4_req_b", fetch_request, 0);
    inst_take = 1'b1;
    beats(16'h3333, 7, 7);
    inst_take = 1'b0;
    check("t4_req_c", fetch_request, 0);
    check("t4_word1", inst_word, 16'h2222);
    take();
    check("t4_word2", inst_word, 16'h3333);
    check("t4_avail2", inst_avail, 1);
    take();
    check("t4_empty", inst_avail, 0);

    // 5. load_imm16 and inst_take together
    fetch();
    fetch();
    beats(16'h0F0F, 0, 7);
    beats(16'h7777, 0, 7);
    load_imm16 = 1'b1;
    inst_take = 1'b1;
    #1;
    check("t5_loaded", imm16_loaded, 1);
    tick();
    load_imm16 = 1'b0;
    inst_take = 1'b0;
    check("t5_next", inst_word, 16'h7777);
    check("t5_avail", inst_avail, 1);
    check("t5_imm", imm_data_in, 2'b11);
    next_imm_data = 1'b1;
    tick(); tick();
    next_imm_data = 1'b0;
    check("t5_imm2", imm_data_in, 2'b00);
    take();
    check("t5_single_pop", inst_avail, 0);

    // 6. reset mid-word
    fetch();
    beats(16'hFFFF, 0, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_avail", inst_avail, 0);
    check("t6_idle", prefetch_idle, 1);
    check("t6_imm", imm_data_in, 0);
    fetch();
    beats(16'h9C3A, 0, 7);
    check("t6_avail2", inst_avail, 1);
    check("t6_word", inst_word, 16'h9C3A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
